// File: rtl/nss_pkg.sv
// rtl/nss_pkg.sv - shared constants and FSM encoding for the nibble serial subtractor
package nss_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } nss_state_t;

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - 4-bit carry-look-ahead adder slice
//
// Ports:
//   x, y : 4-bit addends
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out
module cla4_slice
    import nss_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = x & y;
    assign p = x ^ y;

    // Every carry is expanded directly from g/p/ci so no ripple path exists.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[3:0];
    assign co = c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - multi-cycle subtractor, one CLA nibble per clock
//
// Computes diff = a - b - bin as a + ~b + ~bin, LSB nibble first.
// Optional macro NSS_ADD_MODE_EN adds a mode port: mode=1 computes a + b + bin.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : request, honoured only in IDLE or DONE
//   a, b  : operands, captured on the accepted start
//   bin   : borrow in (carry in when adding), captured on the accepted start
//   mode  : (NSS_ADD_MODE_EN only) 1 = add, 0 = subtract
//   busy  : high while slices are being computed
//   done  : one-cycle pulse, result valid
//   diff  : result, held until the next completed operation
//   bout  : borrow out (raw carry out when adding)
//   ovf   : signed overflow
//   zero  : diff == 0
module nibble_serial_subtractor
    import nss_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef NSS_ADD_MODE_EN
    input  logic             mode,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    nss_state_t state, state_next;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry_r;
    logic             mode_r;
    logic [IW-1:0]    idx;

    logic             add_in;
    logic [NIBBLE_W-1:0] x_nib;
    logic [NIBBLE_W-1:0] y_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic             co;
    logic             accept;
    logic             last;

`ifdef NSS_ADD_MODE_EN
    assign add_in = mode;
`else
    assign add_in = 1'b0;
`endif

    // b is stored raw; inversion happens at the slice input so the sign of
    // the original subtrahend stays available for the overflow rule.
    assign x_nib = a_r[NIBBLE_W*idx +: NIBBLE_W];
    assign y_nib = mode_r ? b_r[NIBBLE_W*idx +: NIBBLE_W]
                          : ~b_r[NIBBLE_W*idx +: NIBBLE_W];

    cla4_slice u_slice (
        .x  (x_nib),
        .y  (y_nib),
        .ci (carry_r),
        .s  (s_nib),
        .co (co)
    );

    always_comb begin
        acc_next = acc;
        acc_next[NIBBLE_W*idx +: NIBBLE_W] = s_nib;
    end

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));
    assign last   = (idx == LAST_IDX);

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = start ? S_RUN : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            carry_r <= 1'b0;
            mode_r  <= 1'b0;
            idx     <= '0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_r     <= a;
                b_r     <= b;
                mode_r  <= add_in;
                carry_r <= add_in ? bin : ~bin;
                acc     <= '0;
                idx     <= '0;
            end else if (state == S_RUN) begin
                acc     <= acc_next;
                carry_r <= co;
                idx     <= idx + 1'b1;
                // Published outputs only change here, on entry to DONE.
                if (last) begin
                    diff <= acc_next;
                    bout <= mode_r ? co : ~co;
                    zero <= (acc_next == '0);
                    if (mode_r)
                        ovf <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                               (acc_next[WIDTH-1] != a_r[WIDTH-1]);
                    else
                        ovf <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                               (acc_next[WIDTH-1] != a_r[WIDTH-1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - self-checking bench for nibble_serial_subtractor
module tb_nibble_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
`ifdef NSS_ADD_MODE_EN
    logic        mode;
`endif
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    int checks = 0;
    int errors = 0;

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
`ifdef NSS_ADD_MODE_EN
        .mode  (mode),
`endif
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                         input logic madd, output logic [15:0] d, output logic bo,
                         output logic ov, output logic z);
        logic [16:0] wide;
        if (madd) begin
            wide = {1'b0, ma} + {1'b0, mb} + {16'd0, mbin};
            d    = wide[15:0];
            bo   = wide[16];
            ov   = (ma[15] == mb[15]) && (d[15] != ma[15]);
        end else begin
            d  = ma - mb - {15'd0, mbin};
            bo = ({1'b0, ma} < ({1'b0, mb} + {16'd0, mbin}));
            ov = (ma[15] != mb[15]) && (d[15] != ma[15]);
        end
        z = (d == 16'd0);
    endtask

    // Called #1 after a rising edge. Drives start for one edge, scrambles the
    // operands afterwards, and waits (bounded) for done, checking the timing.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                          input logic tmode, input logic poke_run);
        int cycles;
        int busy_cnt;
        start = 1'b1; a = ta; b = tb_; bin = tbin;
`ifdef NSS_ADD_MODE_EN
        mode = tmode;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'(($urandom)); b = 16'($urandom); bin = 1'($urandom);
`ifdef NSS_ADD_MODE_EN
        mode = ~tmode;
`endif
        cycles = 0; busy_cnt = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            if (poke_run && cycles == 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
        end
        chk("done_latency", 32'(cycles), 32'd4);
        chk("busy_cycles", 32'(busy_cnt), 32'd4);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_result(input string tag, input logic [15:0] ed, input logic eb,
                              input logic eo, input logic ez);
        chk({tag, "_diff"}, {16'd0, diff}, {16'd0, ed});
        chk({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
        chk({tag, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
    endtask

    initial begin
        logic [15:0] md, ra, rb;
        logic mb, mo, mz, rbin;
        int cycles;
        int done_cnt;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h00FF, 16'h00FF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
`ifdef NSS_ADD_MODE_EN
        mode = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk_result("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors.
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, 1'b0);
            chk_result($sformatf("vec%0d", i), vecs[i].diff, vecs[i].bout,
                       vecs[i].ovf, vecs[i].zero);
            @(posedge clk); #1;
            chk("done_one_pulse", {31'd0, done}, 32'd0);
            chk("hold_diff_idle", {16'd0, diff}, {16'd0, vecs[i].diff});
        end

        // Back-to-back: start held high in the DONE cycle.
        run_op(16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b0);
        chk_result("b2b_first", 16'h0000, 1'b0, 1'b0, 1'b1);
        start = 1'b1; a = 16'h0010; b = 16'h0001; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; a = 16'hAAAA; b = 16'h5555;
        cycles = 0;
        while (!done && cycles < 20) begin
            chk("b2b_hold_diff", {16'd0, diff}, 32'h0);
            @(posedge clk); #1;
            cycles++;
        end
        chk("b2b_latency", 32'(cycles), 32'd4);
        chk_result("b2b_second", 16'h000F, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;

        // start pulsed during RUN is ignored.
        run_op(16'h1234, 16'h0234, 1'b0, 1'b0, 1'b1);
        chk_result("ignore_start", 16'h1000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("ignore_no_rerun", {31'd0, busy}, 32'd0);

        // Reset on the second RUN cycle aborts the operation.
        start = 1'b1; a = 16'h8000; b = 16'h0001; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk_result("abort", 16'h0000, 1'b0, 1'b0, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) done_cnt++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        run_op(16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk_result("after_abort", 16'hFFFF, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Randomised subtract against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) begin ra = 16'h8000; rb = 16'($urandom_range(1, 16'h7FFF)); end
            model(ra, rb, rbin, 1'b0, md, mb, mo, mz);
            run_op(ra, rb, rbin, 1'b0, 1'b0);
            chk_result($sformatf("rand%0d", i), md, mb, mo, mz);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

`ifdef NSS_ADD_MODE_EN
        @(posedge clk); #1;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        chk_result("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            logic rm;
            ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom); rm = 1'($urandom);
            model(ra, rb, rbin, rm, md, mb, mo, mz);
            run_op(ra, rb, rbin, rm, 1'b0);
            chk_result($sformatf("mode%0d", i), md, mb, mo, mz);
            @(posedge clk); #1;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
